// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory port between the fetch stage
//   (IF) and the load/store stage (MEM). A request is sampled in IDLE, the
//   winning command is registered onto the memory port (BUSY_D / BUSY_I) and
//   held until mem_ack. The owner then sees a one-cycle ready pulse in DONE,
//   and the arbiter returns to IDLE.
//
//   Handshake: requests (if_req, d_read, d_write) are levels held by the
//   requester until its ready pulse. ready is a single-cycle completion
//   strobe and rdata is valid in that cycle and held until the next read of
//   the same requester completes. mem_ack is a one-cycle completion strobe
//   from the memory; it is only honoured while a command is outstanding
//   (BUSY_D / BUSY_I). Commands on mem_* are stable for the whole BUSY state.
//
//   Ports:
//     clk, rst                     clock, async active-high reset
//     if_req, if_addr              fetch request / PC
//     if_rdata, if_ready           fetched instruction / completion pulse
//     d_read, d_write, d_addr,
//     d_wdata, d_fn3               load/store request and command
//     d_rdata, d_ready             load data / completion pulse
//     mem_read, mem_write,
//     mem_addr, mem_wdata, mem_fn3 registered memory command
//     mem_rdata, mem_ack           memory response
//
//   Debug visibility: state and wait_cnt are plain named registers so
//   checkers can bind to them directly.
module mem_port_arbiter #(
  parameter int          MAX_WAIT  = 4,
  parameter logic [2:0]  FETCH_FN3 = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_fn3,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_fn3,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;

  logic data_req;
  logic fetch_win;

  // Fetch takes the port when it is the only requester, or when data has
  // already won MAX_WAIT consecutive contested rounds.
  always_comb begin
    data_req  = d_read | d_write;
    fetch_win = if_req & (~data_req | (wait_cnt == WAIT_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      if_rdata  <= 32'd0;
      if_ready  <= 1'b0;
      d_rdata   <= 32'd0;
      d_ready   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_fn3   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_win) begin
            state     <= BUSY_I;
            wait_cnt  <= 4'd0;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'd0;
            mem_fn3   <= FETCH_FN3;
          end else if (data_req) begin
            state     <= BUSY_D;
            // Only a contested round counts against fetch; the counter
            // cannot pass WAIT_LIMIT because fetch wins at that value.
            if (if_req && (wait_cnt != WAIT_LIMIT)) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
            // A store wins if both read and write are raised.
            mem_write <= d_write;
            mem_read  <= d_read & ~d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_fn3   <= d_fn3;
          end
        end

        BUSY_D: begin
          if (mem_ack) begin
            state     <= DONE;
            d_ready   <= 1'b1;
            // mem_read is still the latched command here: a store leaves
            // d_rdata untouched.
            if (mem_read) begin
              d_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end

        BUSY_I: begin
          if (mem_ack) begin
            state     <= DONE;
            if_ready  <= 1'b1;
            if_rdata  <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end

        DONE: begin
          // One cycle of ready with no arbitration, so the requester can
          // drop or change its request before the next IDLE sample.
          state    <= IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified instruction/data memory port between two requesters: the IF stage (fetch) and the MEM stage (load/store).
- Replaces clock-level muxing of the port with a registered request/ack protocol, so the memory may take a variable number of cycles.
- Produces per-requester ready pulses; the pipeline stalls a stage while its request is high and its ready is low.

Parameters:
- MAX_WAIT, 4: consecutive arbitration rounds fetch may lose to data before fetch is forced to win. Legal range 1..15.
- FETCH_FN3, 3'b010: funct3 driven on the memory port for fetches (word access).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_ready.
- if_addr  in  32  fetch address (PC).
- if_rdata  out  32  fetched instruction; valid when if_ready=1, held until the next fetch completes.
- if_ready  out  1  one-cycle completion pulse for a fetch.
- d_read  in  1  load request, level.
- d_write  in  1  store request, level.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_fn3  in  3  access size/sign funct3.
- d_rdata  out  32  load data; valid when d_ready=1, held until the next load completes.
- d_ready  out  1  one-cycle completion pulse for a load or store.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_fn3  out  3  memory funct3.
- mem_rdata  in  32  memory read data; sampled on the mem_ack cycle.
- mem_ack  in  1  memory completion, one cycle; ignored outside the BUSY state.

Behaviour:
- States: IDLE, BUSY_D, BUSY_I, DONE. All mem_*, ready and rdata outputs are registered.
- Reset values: state IDLE, wait_cnt 0, every output 0. Reset mid-transaction aborts it; an ack arriving after reset is ignored.
- IDLE, no request: stay in IDLE; mem_read and mem_write are 0.
- IDLE arbitration on each edge:
  - Data request only (d_read or d_write) -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both requests: data wins unless wait_cnt==MAX_WAIT, in which case fetch wins.
- wait_cnt: incremented when both request and data wins; cleared whenever fetch is granted; saturates at MAX_WAIT.
- Entering BUSY_D latches the data command onto the port:
  - mem_write=d_write, mem_read=d_read & ~d_write (write takes precedence if both are set).
  - mem_addr=d_addr, mem_wdata=d_wdata, mem_fn3=d_fn3.
- Entering BUSY_I latches the fetch command: mem_read=1, mem_write=0, mem_addr=if_addr, mem_wdata=0, mem_fn3=FETCH_FN3.
- The command is therefore visible the cycle after the request is sampled. It is held stable through the whole BUSY state; requester inputs are not re-sampled.
- BUSY_x with mem_ack=1 -> DONE on the next edge. On the same edge:
  - mem_read and mem_write are cleared.
  - The owner's ready is set.
  - For a load or fetch, the owner's rdata is loaded from mem_rdata; a store leaves d_rdata unchanged.
- BUSY_x with mem_ack=0: stay in BUSY_x. There is no timeout.
- DONE lasts exactly one cycle: ready=1, no arbitration, requests are ignored. Then -> IDLE and ready clears. The requester must drop or update its request by the end of the DONE cycle.
- Latency: the minimum is 3 cycles from request sampled to ready (IDLE -> BUSY -> ack -> DONE), plus memory wait cycles. Each transaction occupies at least 3 cycles of the port.
- if_ready and d_ready are never high in the same cycle.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, memory acks 1 cycle after the command with 0x0000_0013 -> next cycle shows mem_read=1, mem_addr=0x10, mem_fn3=010; if_ready pulses once with if_rdata=0x13; state returns to IDLE.
- d_write=1, d_addr=0x40, d_wdata=0xDEAD_BEEF, d_fn3=010, with if_req=1 simultaneously -> the data command is issued first (mem_write=1, mem_wdata=0xDEADBEEF); after d_ready, the fetch is issued in the next arbitration round.
- d_read and if_req held continuously for 6 data transactions, MAX_WAIT=4 -> exactly 4 data grants, then a fetch grant with wait_cnt back to 0; no requester is starved.
- Memory stalls mem_ack for 5 cycles during a load to 0x80 -> mem_addr and mem_read stay stable for all 5 cycles; d_ready pulses once, 1 cycle after the ack.
- Assert rst during BUSY_D, then pulse mem_ack -> all outputs are 0 immediately (asynchronous); the ack is ignored; no ready pulse occurs.
- Set d_read=d_write=1 -> mem_write=1 and mem_read=0; d_rdata is unchanged after d_ready.
